// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM states, stall vector width
// and per-stage stall patterns, and the default general exception entry address.
package pipeline_ctrl_pkg;

  localparam int unsigned STALL_W = 6;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] EXC_VECTOR_DFLT = 32'hBFC0_0380;

  // Each pattern freezes the requesting stage's register and everything upstream of it.
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stage-facing bundle of the pipeline controller: stall requests and the exception
// report flow in, stall/flush/redirect flow out.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic                stallreq_if_i;
  logic                stallreq_id_i;
  logic                stallreq_ex_i;
  logic                stallreq_mem_i;
  logic                excep_valid_i;
  logic                excep_eret_i;
  logic [ADDR_W-1:0]   cp0_epc_i;
  logic [STALL_W-1:0]  stall_o;
  logic                flush_o;
  logic [ADDR_W-1:0]   new_pc_o;

  modport master (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output excep_valid_i, excep_eret_i, cp0_epc_i,
    input  stall_o, flush_o, new_pc_o
  );

  modport slave (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  excep_valid_i, excep_eret_i, cp0_epc_i,
    output stall_o, flush_o, new_pc_o
  );

endinterface

// File: rtl/pipeline_ctrl_stall_encoder.sv
// Combinational priority encoder from per-stage stall requests to the stall vector;
// the deepest requesting stage wins, zero latency.
module stall_encoder
  import pipeline_ctrl_pkg::*;
(
  input  logic               stallreq_if_i,
  input  logic               stallreq_id_i,
  input  logic               stallreq_ex_i,
  input  logic               stallreq_mem_i,
  output logic [STALL_W-1:0] stall_o
);

  always_comb begin
    stall_o = STALL_NONE;
    if (stallreq_mem_i)      stall_o = STALL_MEM;
    else if (stallreq_ex_i)  stall_o = STALL_EX;
    else if (stallreq_id_i)  stall_o = STALL_ID;
    else if (stallreq_if_i)  stall_o = STALL_IF;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/exception controller: priority stalls in RUN, holds for an outstanding
// memory access before flushing, then a one-cycle flush with a registered redirect target.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] EXC_VECTOR = EXC_VECTOR_DFLT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  pipeline_ctrl_if.slave  ctrl
);

  state_t             state_q;
  logic               flush_q;
  logic [ADDR_W-1:0]  target_q;
  logic [ADDR_W-1:0]  target_d;
  logic [STALL_W-1:0] enc_stall;
  logic [STALL_W-1:0] stall_d;

  stall_encoder u_stall_encoder (
    .stallreq_if_i  (ctrl.stallreq_if_i),
    .stallreq_id_i  (ctrl.stallreq_id_i),
    .stallreq_ex_i  (ctrl.stallreq_ex_i),
    .stallreq_mem_i (ctrl.stallreq_mem_i),
    .stall_o        (enc_stall)
  );

  assign target_d = ctrl.excep_eret_i ? ctrl.cp0_epc_i : EXC_VECTOR;

  // The target is captured only when leaving RUN, so EPC changes while waiting are ignored.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= ST_RUN;
      flush_q  <= 1'b0;
      target_q <= '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          flush_q <= 1'b0;
          if (ctrl.excep_valid_i) begin
            target_q <= target_d;
            if (ctrl.stallreq_mem_i) begin
              state_q <= ST_WAIT_MEM;
            end else begin
              state_q <= ST_FLUSH;
              flush_q <= 1'b1;
            end
          end
        end
        ST_WAIT_MEM: begin
          if (!ctrl.stallreq_mem_i) begin
            state_q <= ST_FLUSH;
            flush_q <= 1'b1;
          end
        end
        ST_FLUSH: begin
          state_q <= ST_RUN;
          flush_q <= 1'b0;
        end
        default: begin
          state_q <= ST_RUN;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall_d = enc_stall;
    case (state_q)
      ST_WAIT_MEM: stall_d = STALL_MEM;
      ST_FLUSH:    stall_d = STALL_NONE;
      default:     stall_d = enc_stall;
    endcase
  end

  assign ctrl.stall_o  = stall_d;
  assign ctrl.flush_o  = flush_q;
  assign ctrl.new_pc_o = target_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with constant expectations plus a
// randomized run compared against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam logic [31:0] EXC = 32'hBFC0_0380;

  logic clk_i;
  logic rst_i;
  int   checks;
  int   failures;

  // Model: an accepted exception is either waiting on memory or flushing next.
  bit          m_wait;
  bit          m_flush;
  logic [31:0] m_target;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.EXC_VECTOR(EXC)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ctrl  (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [5:0] run_stall(input logic fi, input logic di, input logic ei,
                                           input logic mi);
    int depth;
    depth = mi ? 4 : ei ? 3 : di ? 2 : fi ? 1 : 0;
    if (depth == 0) return 6'd0;
    return 6'((32'd1 << (depth + 1)) - 32'd1);
  endfunction

  function automatic logic [5:0] model_stall();
    if (m_flush) return 6'd0;
    if (m_wait)  return 6'b011111;
    return run_stall(bus.stallreq_if_i, bus.stallreq_id_i, bus.stallreq_ex_i,
                     bus.stallreq_mem_i);
  endfunction

  task automatic drive(input logic fi, input logic di, input logic ei, input logic mi,
                       input logic v, input logic er, input logic [31:0] epc);
    bus.stallreq_if_i  = fi;
    bus.stallreq_id_i  = di;
    bus.stallreq_ex_i  = ei;
    bus.stallreq_mem_i = mi;
    bus.excep_valid_i  = v;
    bus.excep_eret_i   = er;
    bus.cp0_epc_i      = epc;
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (!rst_i) begin
      m_wait = 0; m_flush = 0; m_target = 32'h0;
    end else if (m_flush) begin
      m_flush = 0;
    end else if (m_wait) begin
      if (!bus.stallreq_mem_i) begin m_wait = 0; m_flush = 1; end
    end else if (bus.excep_valid_i) begin
      m_target = bus.excep_eret_i ? bus.cp0_epc_i : EXC;
      if (bus.stallreq_mem_i) m_wait = 1; else m_flush = 1;
    end
    @(negedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    tick(); tick();
    checks++;
    if (bus.flush_o !== 1'b0 || bus.new_pc_o !== 32'h0 || bus.stall_o !== 6'd0) begin
      failures++;
      $display("FAIL reset_idle: flush=%b pc=%h stall=%b, want 0/0/000000",
               bus.flush_o, bus.new_pc_o, bus.stall_o);
    end
    drive(0, 0, 0, 1, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.stall_o !== 6'b011111) begin
      failures++;
      $display("FAIL reset_stall_mem: stall=%b want 011111", bus.stall_o);
    end
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    tick();
    rst_i = 1'b1;
    #1;
  endtask

  task automatic test_stall_priority();
    logic [5:0] exp;
    for (int k = 0; k < 16; k++) begin
      drive(k[0], k[1], k[2], k[3], 0, 0, 32'h0);
      #1;
      exp = run_stall(k[0], k[1], k[2], k[3]);
      checks++;
      if (bus.stall_o !== exp) begin
        failures++;
        $display("FAIL stall_prio[%0d]: stall=%b want %b", k, bus.stall_o, exp);
      end
      tick();
    end
    drive(1, 0, 1, 0, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.stall_o !== 6'b001111) begin
      failures++;
      $display("FAIL stall_ex_if: stall=%b want 001111", bus.stall_o);
    end
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.stall_o !== 6'b000000) begin
      failures++;
      $display("FAIL stall_none: stall=%b want 000000", bus.stall_o);
    end
  endtask

  task automatic test_exc_vector();
    drive(0, 0, 0, 0, 1, 0, 32'h1234_5678);
    tick();
    drive(1, 1, 1, 1, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.flush_o !== 1'b1 || bus.new_pc_o !== EXC || bus.stall_o !== 6'd0) begin
      failures++;
      $display("FAIL exc_flush: flush=%b pc=%h stall=%b, want 1/%h/000000",
               bus.flush_o, bus.new_pc_o, bus.stall_o, EXC);
    end
    drive(0, 0, 1, 0, 0, 0, 32'h0);
    tick();
    checks++;
    if (bus.flush_o !== 1'b0 || bus.new_pc_o !== EXC || bus.stall_o !== 6'b001111) begin
      failures++;
      $display("FAIL exc_after: flush=%b pc=%h stall=%b, want 0/%h/001111",
               bus.flush_o, bus.new_pc_o, bus.stall_o, EXC);
    end
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    tick();
  endtask

  task automatic test_eret();
    drive(0, 0, 0, 0, 1, 1, 32'h8000_1234);
    tick();
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'h8000_1234) begin
      failures++;
      $display("FAIL eret_flush: flush=%b pc=%h, want 1/80001234", bus.flush_o, bus.new_pc_o);
    end
    tick();
    checks++;
    if (bus.flush_o !== 1'b0) begin
      failures++;
      $display("FAIL eret_one_cycle: flush=%b want 0", bus.flush_o);
    end
  endtask

  task automatic test_mem_wait();
    drive(0, 0, 0, 1, 1, 1, 32'hA000_0010);
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 1) drive(0, 1, 0, 1, 1, 0, 32'hA000_0010);
      if (c == 2) drive(0, 0, 0, 1, 0, 0, 32'hC000_0020);
      if (c == 3) drive(1, 0, 0, 1, 0, 0, 32'hC000_0020);
      if (c == 4) drive(0, 0, 0, 0, 0, 0, 32'hC000_0020);
      #1;
      checks++;
      if (bus.stall_o !== 6'b011111 || bus.flush_o !== 1'b0) begin
        failures++;
        $display("FAIL mem_wait[N+%0d]: stall=%b flush=%b, want 011111/0",
                 c, bus.stall_o, bus.flush_o);
      end
      tick();
    end
    checks++;
    if (bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'hA000_0010) begin
      failures++;
      $display("FAIL mem_flush: flush=%b pc=%h, want 1/a0000010", bus.flush_o, bus.new_pc_o);
    end
    tick();
    checks++;
    if (bus.flush_o !== 1'b0) begin
      failures++;
      $display("FAIL mem_flush_end: flush=%b want 0", bus.flush_o);
    end
  endtask

  task automatic test_flush_squash();
    drive(0, 0, 0, 0, 1, 0, 32'h0);
    tick();
    drive(0, 0, 0, 0, 1, 1, 32'hDEAD_BEE0);
    #1;
    checks++;
    if (bus.flush_o !== 1'b1 || bus.new_pc_o !== EXC) begin
      failures++;
      $display("FAIL squash_first: flush=%b pc=%h, want 1/%h", bus.flush_o, bus.new_pc_o, EXC);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.flush_o !== 1'b0 || bus.new_pc_o !== EXC) begin
      failures++;
      $display("FAIL squash_second: flush=%b pc=%h, want 0/%h", bus.flush_o, bus.new_pc_o, EXC);
    end
    tick();
    checks++;
    if (bus.flush_o !== 1'b0) begin
      failures++;
      $display("FAIL squash_later: flush=%b want 0", bus.flush_o);
    end
  endtask

  task automatic test_reset_in_wait();
    drive(0, 0, 0, 1, 1, 1, 32'h9000_0040);
    tick();
    drive(0, 0, 0, 1, 0, 0, 32'h0);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.flush_o !== 1'b0 || bus.new_pc_o !== 32'h0 || bus.stall_o !== 6'd0) begin
      failures++;
      $display("FAIL rst_wait: flush=%b pc=%h stall=%b, want 0/0/000000",
               bus.flush_o, bus.new_pc_o, bus.stall_o);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.flush_o !== 1'b0 || bus.new_pc_o !== 32'h0) begin
        failures++;
        $display("FAIL rst_wait_no_flush[%0d]: flush=%b pc=%h, want 0/0",
                 c, bus.flush_o, bus.new_pc_o);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] exp_stall;
    for (int n = 0; n < 600; n++) begin
      rst_i = ($urandom_range(0, 49) != 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), $urandom());
      #1;
      exp_stall = model_stall();
      checks++;
      if (bus.stall_o !== exp_stall || bus.flush_o !== m_flush || bus.new_pc_o !== m_target) begin
        failures++;
        $display("FAIL random[%0d]: stall=%b flush=%b pc=%h, want %b/%b/%h",
                 n, bus.stall_o, bus.flush_o, bus.new_pc_o, exp_stall, m_flush, m_target);
      end
      tick();
    end
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_wait   = 0;
    m_flush  = 0;
    m_target = 32'h0;
    rst_i    = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk_i);
    test_reset();
    test_stall_priority();
    test_exc_vector();
    test_eret();
    test_mem_wait();
    test_flush_squash();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL provide parameter EXC_VECTOR, default 32'hBFC0_0380, general exception entry address.
REQ-002 SHALL provide clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide rst_i  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide stallreq_if_i  input  1  fetch stage requests stall.
REQ-005 SHALL provide stallreq_id_i  input  1  decode stage requests stall.
REQ-006 SHALL provide stallreq_ex_i  input  1  execute stage requests stall (multi-cycle op).
REQ-007 SHALL provide stallreq_mem_i  input  1  memory stage requests stall (data access outstanding).
REQ-008 SHALL provide excep_valid_i  input  1  memory stage reports exception or ERET this cycle.
REQ-009 SHALL provide excep_eret_i  input  1  qualifies excep_valid_i as ERET.
REQ-010 SHALL provide cp0_epc_i  input  32  current EPC from CP0.
REQ-011 SHALL provide stall_o  output  6  per-register stall; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (always 0).
REQ-012 SHALL provide flush_o  output  1  flush to all pipeline registers.
REQ-013 SHALL provide new_pc_o  output  32  redirect target, valid when flush_o=1.

Function
REQ-014 SHALL implement states RUN, WAIT_MEM, FLUSH.
REQ-015 In RUN with no exception, stall_o SHALL be combinational from the deepest requester: mem 6'b011111, else ex 6'b001111, else id 6'b000111, else if 6'b000011, else 6'b000000.
REQ-016 RUN, excep_valid_i=1, stallreq_mem_i=0 SHALL go to FLUSH next cycle, latching target (cp0_epc_i if excep_eret_i, else EXC_VECTOR).
REQ-017 RUN, excep_valid_i=1, stallreq_mem_i=1 SHALL go to WAIT_MEM, latching target as in REQ-016.
REQ-018 WAIT_MEM SHALL drive stall_o=6'b011111, flush_o=0, ignore excep_valid_i, and move to FLUSH in the cycle after stallreq_mem_i is sampled 0.
REQ-019 FLUSH SHALL last exactly one cycle: flush_o=1, new_pc_o=latched target, stall_o=0 regardless of requests; then RUN.
REQ-020 excep_valid_i during FLUSH SHALL be ignored (squashed instruction).
REQ-021 Outside FLUSH, flush_o SHALL be 0 and new_pc_o SHALL hold last latched target.
REQ-022 Latched target SHALL be sampled only on the RUN-exit cycle; later cp0_epc_i changes SHALL not affect it.
REQ-023 Latency exception-in to flush_o SHALL be 1 cycle unstalled, k+1 cycles when memory stalls k further cycles.

Reset
REQ-024 rst_i=0 at a rising edge SHALL force RUN and clear latched target to 0, overriding any WAIT_MEM/FLUSH in progress.
REQ-025 During and after reset until a new exception: flush_o=0, new_pc_o=32'h0, stall_o per REQ-015.

Structure
REQ-026 State enum, stall-vector width, and EXC_VECTOR default SHALL live in the shared defines package.
REQ-027 Priority stall encoding SHALL be one combinational sub-module, stall_encoder; state and target registers stay in pipeline_ctrl.

Verification
REQ-028 stallreq_ex_i=1 and stallreq_if_i=1, others 0 -> stall_o=6'b001111; all 0 -> 6'b000000.
REQ-029 excep_valid_i=1, excep_eret_i=0 at cycle N, no mem stall -> cycle N+1 flush_o=1, new_pc_o=32'hBFC00380, stall_o=0; N+2 flush_o=0.
REQ-030 excep_valid_i=1, excep_eret_i=1, cp0_epc_i=32'h8000_1234 -> one-cycle flush_o with new_pc_o=32'h8000_1234.
REQ-031 Exception at N with stallreq_mem_i high N..N+3, low N+4, cp0_epc_i changed at N+2 -> stall_o=6'b011111 N+1..N+4, flush_o=1 only at N+5 with target latched at N.
REQ-032 Second excep_valid_i during FLUSH -> no second flush pulse.
REQ-033 rst_i=0 while in WAIT_MEM -> next cycle RUN, flush_o=0, new_pc_o=0; no flush after stallreq_mem_i drops.
